simon_arbiter: RTL and testbench
================================

Name: simon_arbiter

Overview:
Shares one top_simon core (Simon128/128) between N_REQ independent requesters using round-robin arbitration. Each request uses a valid/ready handshake carrying a 128-bit plaintext and key. The block pulses the core start, waits for completion with a timeout guard, and returns the ciphertext to the granted requester over a second valid/ready channel. It sits between bus-side interface blocks or DMA-style clients and a single shared top_simon instance.

Parameters:
N_REQ, 2, number of requesters (2..8)
TIMEOUT_CYC, 255, WAIT cycles before an operation is abandoned with error (1..65535)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
req_valid_i  in  N_REQ  request present, one bit per requester
req_ready_o  out  N_REQ  request accepted this cycle (one-hot or zero)
req_pt_i  in  N_REQ x 128  plaintext per requester
req_key_i  in  N_REQ x 128  key per requester
rsp_valid_o  out  N_REQ  response valid for the granted requester (one-hot or zero)
rsp_ready_i  in  N_REQ  requester accepts response
rsp_ct_o  out  128  ciphertext, shared by all requesters
rsp_err_o  out  1  response is a timeout error; ct is zero
core_start_o  out  1  single-cycle start to top_simon
core_pt_o  out  128  plaintext to core
core_key_o  out  128  key to core
core_valid_i  in  1  top_simon valid_o (level)
core_ct_i  in  128  top_simon ct_o
busy_o  out  1  state != IDLE
grant_o  out  $clog2(N_REQ) (min 1)  index of current or last grant

Behaviour:
- Reset: every output, latched pt/key/ct, counter and valid_q are 0. grant_o=0, rr pointer=N_REQ-1, so requester 0 has first priority. State is IDLE.
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req_valid_i is set, pick the first set bit searching circularly from ptr+1.
  - req_ready_o[g] is asserted combinationally in that cycle.
  - Latch req_pt_i[g] and req_key_i[g], set grant_o=g, go to ISSUE.
  - With no requests, remain in IDLE and drive all ready bits 0.
- ISSUE: core_start_o=1 for exactly this cycle. Clear the counter and go to WAIT.
- core_pt_o and core_key_o are driven from the latched registers and stay stable from ISSUE through RESP.
- valid_q is a register that samples core_valid_i every cycle. Completion is a rising edge only: core_valid_i & ~valid_q. A level still high from the previous operation is not completion.
- WAIT:
  - The counter increments each cycle.
  - On completion, latch core_ct_i into rsp_ct_o, set rsp_err_o=0, go to RESP.
  - Otherwise, when the counter reaches TIMEOUT_CYC-1, set rsp_ct_o=0, rsp_err_o=1, go to RESP.
  - If completion and timeout occur in the same cycle, completion wins.
- RESP:
  - rsp_valid_o[g]=1, held with rsp_ct_o and rsp_err_o stable until rsp_ready_i[g].
  - On the handshake cycle, set ptr=g and go to IDLE.
  - The next arbitration happens in the IDLE cycle after that; there is no IDLE bypass.
- Latency: acceptance to rsp_valid is 3 cycles plus the core latency (edge seen in WAIT). At most one operation is in flight.
- Requests are not queued. A requester whose req_valid_i drops before grant is simply not picked.
- rsp_ready_i bits of non-granted requesters are ignored.
- rst_n asserted mid-operation: immediate return to reset values and the operation is dropped. core_start_o is never re-issued.
- Fairness: a requester holding req_valid_i continuously is served within N_REQ operations.

Decomposition:
- simon_pkg holds: SIMON_BLK_W=128, SIMON_KEY_W=128, and the state enum (ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP).
- Sub-module rr_arbiter: combinational round-robin pick from req vector and ptr. Outputs one-hot grant, index and any_req.
- Counter, FSM and latches stay in simon_arbiter.

Test Plan:
1. Single request, N_REQ=2, real top_simon:
   - Stimulus: req0 with key=0f0e0d0c0b0a09080706050403020100, pt=63736564207372656c6c657661727420.
   - Response: one core_start pulse; rsp_valid_o=01; rsp_ct_o=49681b1e1e54fe3f65aa832af84e0bbc; rsp_err_o=0.
2. Both requesters held valid for 4 operations -> grant order 0,1,0,1; each rsp_valid_o only on the granted bit.
3. Behavioural core, latency 10:
   - Stimulus: hold rsp_ready_i low for 5 cycles after rsp_valid.
   - Response: rsp_ct_o and rsp_valid_o stable for all 5 cycles; next req_ready_o no earlier than 1 cycle after the handshake.
4. Core whose valid never rises, TIMEOUT_CYC=20 -> rsp_valid after exactly 20 WAIT cycles with rsp_err_o=1 and rsp_ct_o=0; the next request is served normally.
5. core_valid_i held high from the previous op and deasserted 3 cycles after start, then risen again -> completion only on the new rising edge; stale level ignored.
6. rst_n pulsed low during WAIT -> all outputs 0 asynchronously; after release, a pending req1 gets no ready until IDLE arbitration; no spurious rsp_valid_o.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared widths and FSM states for the Simon core arbiter.
// Imported by simon_arbiter.
package simon_pkg;

  localparam int SIMON_BLK_W = 128;
  localparam int SIMON_KEY_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/simon_arbiter_rr.sv
// Round-robin pick: searches i_req circularly from i_ptr+1.
// Ports: i_req, i_ptr in; o_gnt one-hot, o_idx, o_any out.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IW    = 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  always_comb begin
    int j;
    j     = 0;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      j = (int'(i_ptr) + i) % N_REQ;
      if (!o_any && i_req[j]) begin
        o_any    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/simon_arbiter.sv
// Shares one Simon128/128 core between N_REQ requesters (round robin).
// Ports: req_* in, rsp_* out, core_* to/from top_simon, busy_o, grant_o.
module simon_arbiter
  import simon_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int TIMEOUT_CYC = 255,
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_REQ-1:0]               req_valid_i,
  output logic [N_REQ-1:0]               req_ready_o,
  input  logic [N_REQ*SIMON_BLK_W-1:0]   req_pt_i,
  input  logic [N_REQ*SIMON_KEY_W-1:0]   req_key_i,
  output logic [N_REQ-1:0]               rsp_valid_o,
  input  logic [N_REQ-1:0]               rsp_ready_i,
  output logic [SIMON_BLK_W-1:0]         rsp_ct_o,
  output logic                           rsp_err_o,
  output logic                           core_start_o,
  output logic [SIMON_BLK_W-1:0]         core_pt_o,
  output logic [SIMON_KEY_W-1:0]         core_key_o,
  input  logic                           core_valid_i,
  input  logic [SIMON_BLK_W-1:0]         core_ct_i,
  output logic                           busy_o,
  output logic [IW-1:0]                  grant_o
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  arb_state_e             r_state;
  logic [IW-1:0]          r_ptr;
  logic [IW-1:0]          r_grant;
  logic [SIMON_BLK_W-1:0] r_pt;
  logic [SIMON_KEY_W-1:0] r_key;
  logic [SIMON_BLK_W-1:0] r_ct;
  logic                   r_err;
  logic [15:0]            r_cnt;
  logic                   r_start;
  logic [N_REQ-1:0]       r_rsp_v;
  logic                   r_vq;

  logic [N_REQ-1:0]       w_gnt;
  logic [IW-1:0]          w_idx;
  logic                   w_any;
  logic                   w_done;
  logic [N_REQ-1:0]       w_goh;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr (
    .i_req (req_valid_i),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // Only a fresh rising edge counts; a level left over
  // from the previous operation is ignored.
  assign w_done = core_valid_i & ~r_vq;
  assign w_goh  = N_REQ'(1) << r_grant;

  // Gated by rst_n so ready is low while reset is held.
  assign req_ready_o =
    (r_state == ST_IDLE && rst_n) ? w_gnt : '0;

  assign rsp_valid_o  = r_rsp_v;
  assign rsp_ct_o     = r_ct;
  assign rsp_err_o    = r_err;
  assign core_start_o = r_start;
  assign core_pt_o    = r_pt;
  assign core_key_o   = r_key;
  assign busy_o       = (r_state != ST_IDLE);
  assign grant_o      = r_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= IW'(N_REQ - 1);
      r_grant <= '0;
      r_pt    <= '0;
      r_key   <= '0;
      r_ct    <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_start <= 1'b0;
      r_rsp_v <= '0;
      r_vq    <= 1'b0;
    end else begin
      r_vq    <= core_valid_i;
      r_start <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_pt    <= req_pt_i[int'(w_idx)*SIMON_BLK_W +: SIMON_BLK_W];
            r_key   <= req_key_i[int'(w_idx)*SIMON_KEY_W +: SIMON_KEY_W];
            r_grant <= w_idx;
            r_start <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_done) begin
            r_ct    <= core_ct_i;
            r_err   <= 1'b0;
            r_rsp_v <= w_goh;
            r_state <= ST_RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_ct    <= '0;
            r_err   <= 1'b1;
            r_rsp_v <= w_goh;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i[r_grant]) begin
            r_rsp_v <= '0;
            r_ptr   <= r_grant;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_arbiter.sv
// Self-checking bench for simon_arbiter with a behavioural Simon core.
// Table-driven operations plus hand sequences for KAT and reset.
module tb_simon_arbiter;

  localparam int TMO = 20;

  localparam logic [127:0] KAT_KEY =
    128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] KAT_PT =
    128'h63736564207372656c6c657661727420;
  localparam logic [127:0] KAT_CT =
    128'h49681b1e1e54fe3f65aa832af84e0bbc;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready_o;
  logic [127:0] pt_v [2];
  logic [127:0] key_v [2];
  logic [255:0] w_pt;
  logic [255:0] w_key;
  logic [1:0]   rsp_valid_o;
  logic [1:0]   rsp_ready;
  logic [127:0] rsp_ct_o;
  logic         rsp_err_o;
  logic         core_start_o;
  logic [127:0] core_pt_o;
  logic [127:0] core_key_o;
  logic         cvalid;
  logic [127:0] cct;
  logic         busy_o;
  logic [0:0]   grant_o;

  assign w_pt  = {pt_v[1], pt_v[0]};
  assign w_key = {key_v[1], key_v[0]};

  simon_arbiter #(
    .N_REQ       (2),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .req_pt_i     (w_pt),
    .req_key_i    (w_key),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready),
    .rsp_ct_o     (rsp_ct_o),
    .rsp_err_o    (rsp_err_o),
    .core_start_o (core_start_o),
    .core_pt_o    (core_pt_o),
    .core_key_o   (core_key_o),
    .core_valid_i (cvalid),
    .core_ct_i    (cct),
    .busy_o       (busy_o),
    .grant_o      (grant_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rol64(
    input logic [63:0] v, input int n);
    return (v << n) | (v >> (64 - n));
  endfunction

  function automatic logic [127:0] simon128(
    input logic [127:0] pt, input logic [127:0] key);
    logic [61:0] z;
    logic [63:0] k [68];
    logic [63:0] x, y, t;
    z = 62'b10101111011100000011010010011000101000010001111110010110110011;
    k[0] = key[63:0];
    k[1] = key[127:64];
    for (int i = 2; i < 68; i++) begin
      t = rol64(k[i-1], 61);
      t = t ^ rol64(t, 63);
      k[i] = ~k[i-2] ^ t ^ {63'd0, z[61 - ((i - 2) % 62)]} ^ 64'd3;
    end
    x = pt[127:64];
    y = pt[63:0];
    for (int i = 0; i < 68; i++) begin
      t = x;
      x = y ^ ((rol64(x, 1) & rol64(x, 8)) ^ rol64(x, 2)) ^ k[i];
      y = t;
    end
    return {x, y};
  endfunction

  // Behavioural core: valid drops `drop` edges after start and
  // rises `lat` edges after start unless `never` is set.
  int           lat = 10;
  int           drop = 1;
  bit           never = 1'b0;
  int           cc;
  logic [127:0] mpt, mkey;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cvalid <= 1'b0;
      cct    <= '0;
      cc     <= 0;
      mpt    <= '0;
      mkey   <= '0;
    end else if (core_start_o) begin
      cc   <= 1;
      mpt  <= core_pt_o;
      mkey <= core_key_o;
    end else if (cc != 0) begin
      if (cc == drop) cvalid <= 1'b0;
      if (cc == lat && !never) begin
        cvalid <= 1'b1;
        cct    <= simon128(mpt, mkey);
      end
      cc <= (cc > 100) ? 0 : cc + 1;
    end
  end

  int cyc = 0;
  int start_cyc = 0;
  int start_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (core_start_o) begin
      start_cyc <= cyc;
      start_cnt <= start_cnt + 1;
    end
  end

  int total = 0;
  int passed = 0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_ready"}, 128'(req_ready_o), 128'(0));
    chk({p, "_rspv"}, 128'(rsp_valid_o), 128'(0));
    chk({p, "_start"}, 128'(core_start_o), 128'(0));
    chk({p, "_busy"}, 128'(busy_o), 128'(0));
    chk({p, "_grant"}, 128'(grant_o), 128'(0));
    chk({p, "_ct"}, rsp_ct_o, 128'(0));
    chk({p, "_err"}, 128'(rsp_err_o), 128'(0));
    chk({p, "_cpt"}, core_pt_o, 128'(0));
    chk({p, "_ckey"}, core_key_o, 128'(0));
  endtask

  typedef struct {
    logic [1:0] rv;
    int         eg;
    logic       err;
    int         lat;
    int         drop;
    bit         never;
    int         hold;
  } op_t;

  op_t tbl [9];

  // Called just after a negedge; returns just after a negedge
  // with the DUT back in IDLE.
  task automatic do_op(input op_t o);
    int n;
    int s0;
    logic [1:0]   eoh;
    logic [127:0] ect;
    eoh   = 2'b01 << o.eg;
    lat   = o.lat;
    drop  = o.drop;
    never = o.never;
    rsp_ready = '0;
    req_valid = o.rv;
    s0 = start_cnt;
    n  = 0;
    #1;
    while (req_ready_o == 2'b00 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("req_ready", 128'(req_ready_o), 128'(eoh));
    @(negedge clk);
    chk("core_start", 128'(core_start_o), 128'(1));
    chk("core_pt", core_pt_o, pt_v[o.eg]);
    chk("core_key", core_key_o, key_v[o.eg]);
    n = 0;
    while (rsp_valid_o == 2'b00 && n < 60) begin
      @(negedge clk);
      n++;
    end
    ect = o.err ? 128'(0) : simon128(pt_v[o.eg], key_v[o.eg]);
    chk("rsp_valid", 128'(rsp_valid_o), 128'(eoh));
    chk("rsp_err", 128'(rsp_err_o), 128'(o.err));
    chk("rsp_ct", rsp_ct_o, ect);
    chk("grant", 128'(grant_o), 128'(o.eg));
    chk("latency", 128'(cyc - start_cyc),
        128'(o.err ? TMO + 1 : o.lat + 2));
    chk("start_cnt", 128'(start_cnt - s0), 128'(1));
    rsp_ready = ~eoh;
    for (int i = 0; i < o.hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 128'(rsp_valid_o), 128'(eoh));
      chk("hold_ct", rsp_ct_o, ect);
    end
    rsp_ready = 2'b11;
    #1;
    chk("ready_in_resp", 128'(req_ready_o), 128'(0));
    @(negedge clk);
    chk("rsp_clear", 128'(rsp_valid_o), 128'(0));
    chk("idle", 128'(busy_o), 128'(0));
    rsp_ready = '0;
    req_valid = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int n_w;
  int s_w;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    pt_v[0]   = KAT_PT;
    key_v[0]  = KAT_KEY;
    pt_v[1]   = 128'h00112233445566778899aabbccddeeff;
    key_v[1]  = 128'hfedcba98765432100123456789abcdef;

    //           rv    eg err lat drop never hold
    tbl[0] = '{2'b11, 0, 1'b0, 10, 1, 1'b0, 1};
    tbl[1] = '{2'b11, 1, 1'b0, 10, 1, 1'b0, 1};
    tbl[2] = '{2'b11, 0, 1'b0, 10, 1, 1'b0, 1};
    tbl[3] = '{2'b11, 1, 1'b0, 10, 1, 1'b0, 1};
    tbl[4] = '{2'b01, 0, 1'b0, 10, 1, 1'b0, 5};
    tbl[5] = '{2'b10, 1, 1'b1, 10, 1, 1'b1, 1};
    tbl[6] = '{2'b11, 0, 1'b0, 10, 1, 1'b0, 1};
    tbl[7] = '{2'b11, 1, 1'b0,  6, 3, 1'b0, 1};
    tbl[8] = '{2'b10, 1, 1'b0,  4, 1, 1'b0, 1};

    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    do_op('{2'b01, 0, 1'b0, 10, 1, 1'b0, 1});
    chk("kat_ct", rsp_ct_o, KAT_CT);

    do_reset();
    for (int i = 0; i < 9; i++) do_op(tbl[i]);

    lat   = 10;
    drop  = 1;
    never = 1'b0;
    req_valid = 2'b10;
    n_w = 0;
    #1;
    while (req_ready_o == 2'b00 && n_w < 40) begin
      @(negedge clk);
      #1;
      n_w++;
    end
    chk("t6_ready", 128'(req_ready_o), 128'(2'b10));
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("t6_busy", 128'(busy_o), 128'(1));
    s_w = start_cnt;
    #2 rst_n = 1'b0;
    #1 chk_zero("t6_rst");
    @(negedge clk);
    @(negedge clk);
    chk("t6_rst_rspv", 128'(rsp_valid_o), 128'(0));
    rst_n = 1'b1;
    chk("t6_nostart", 128'(start_cnt - s_w), 128'(0));
    do_op('{2'b10, 1, 1'b0, 10, 1, 1'b0, 1});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
